nn_mem_seq_ctrl: RTL

Parametrised sequencer for the neural-net kernel memory (KMEM, dual-port) and weight memory (WMEM, dual-port).
- Learn command: runs a fixed-length write burst.
- Classify command: runs a multi-pair kernel/weight read sequence, with a read-latency-aligned data-valid pipeline to the MAC datapath.
- Adds to the previous controller: bounded sequences, a done handshake, an abort input, and chip-select gating while idle.

---
 rtl/nn_mem_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/nn_mem_seq_ctrl.sv
// nn_mem_seq_ctrl: sequencer for the dual-port kernel (KMEM) and weight (WMEM)
// memories of the neural-net kernel.
//   learn    : fixed LEARN_CYC-cycle write burst into both memories.
//   classify : KPAIRS x CLASS_CYC read sequence; En/En_first follow the issued
//              reads by RD_LAT cycles to qualify data at the memory outputs.
// Ports:
//   clk, rst (async, active-low)
//   learn, classify  start requests, sampled only while idle (learn wins)
//   abort            terminate the current operation, no done pulse
//   KMEM_* / WMEM_*  addresses and active-low WEB/OEB/CSB per memory port
//   En, En_first     read-data valid / first weight of a kernel pair
//   busy, done       operation in progress / one-cycle completion pulse
module nn_mem_seq_ctrl #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned LEARN_CYC = 4,
  parameter int unsigned KPAIRS    = 1,
  parameter int unsigned CLASS_CYC = 4,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              learn,
  input  logic              classify,
  input  logic              abort,
  output logic [ADDR_W-1:0] KMEM_A1,
  output logic [ADDR_W-1:0] KMEM_A2,
  output logic [ADDR_W-1:0] WMEM_A1,
  output logic [ADDR_W-1:0] WMEM_A2,
  output logic              KMEM_WEB1,
  output logic              KMEM_OEB1,
  output logic              KMEM_CSB1,
  output logic              KMEM_WEB2,
  output logic              KMEM_OEB2,
  output logic              KMEM_CSB2,
  output logic              WMEM_WEB1,
  output logic              WMEM_OEB1,
  output logic              WMEM_CSB1,
  output logic              WMEM_WEB2,
  output logic              WMEM_OEB2,
  output logic              WMEM_CSB2,
  output logic              En,
  output logic              En_first,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CW = (LEARN_CYC > 1) ? $clog2(LEARN_CYC) : 1;
  localparam int unsigned PW = (KPAIRS    > 1) ? $clog2(KPAIRS)    : 1;
  localparam int unsigned RW = (CLASS_CYC > 1) ? $clog2(CLASS_CYC) : 1;
  localparam int unsigned DW = (RD_LAT    > 1) ? $clog2(RD_LAT)    : 1;
  // Pipeline depth kept legal even for an illegal RD_LAT so the error below is reported cleanly
  localparam int unsigned PL = (RD_LAT    > 0) ? RD_LAT            : 1;

  // Elaboration-time parameter checks
  if (64'(2 * LEARN_CYC) > (64'(1) << ADDR_W)) begin : g_chk_learn
    $error("nn_mem_seq_ctrl: 2*LEARN_CYC exceeds the address space");
  end
  if (64'(2 * KPAIRS) > (64'(1) << ADDR_W)) begin : g_chk_kpairs
    $error("nn_mem_seq_ctrl: 2*KPAIRS exceeds the address space");
  end
  if (64'(KPAIRS * CLASS_CYC) > (64'(1) << ADDR_W)) begin : g_chk_class
    $error("nn_mem_seq_ctrl: KPAIRS*CLASS_CYC exceeds the address space");
  end
  if (RD_LAT < 1) begin : g_chk_lat
    $error("nn_mem_seq_ctrl: RD_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_LEARN    = 2'd1,
    S_CLASSIFY = 2'd2,
    S_DRAIN    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   c_q, c_d;
  logic [PW-1:0]   p_q, p_d;
  logic [RW-1:0]   r_q, r_d;
  logic [DW-1:0]   d_q, d_d;
  logic [PL-1:0]   vld_q, vld_d;
  logic [PL-1:0]   fst_q, fst_d;

  logic            c_last, p_last, r_last, d_last;
  logic            push_v, push_f;

  assign c_last = (c_q == CW'(LEARN_CYC - 1));
  assign p_last = (p_q == PW'(KPAIRS - 1));
  assign r_last = (r_q == RW'(CLASS_CYC - 1));
  assign d_last = (d_q == DW'(RD_LAT - 1));

  // State, counters and read-valid pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      c_q     <= '0;
      p_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      vld_q   <= '0;
      fst_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      p_q     <= p_d;
      r_q     <= r_d;
      d_q     <= d_d;
      vld_q   <= vld_d;
      fst_q   <= fst_d;
    end
  end

  // Next-state, counter and pipeline update
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    p_d     = p_q;
    r_d     = r_q;
    d_d     = d_q;
    push_v  = 1'b0;
    push_f  = 1'b0;
    vld_d   = '0;
    fst_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (learn) begin
          state_d = S_LEARN;
        end else if (classify) begin
          state_d = S_CLASSIFY;
        end
      end
      S_LEARN: begin
        if (c_last) begin
          c_d     = '0;
          state_d = S_IDLE;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_CLASSIFY: begin
        push_v = 1'b1;
        push_f = (r_q == '0);
        if (r_last) begin
          r_d = '0;
          if (p_last) begin
            p_d     = '0;
            state_d = S_DRAIN;
          end else begin
            p_d = p_q + PW'(1);
          end
        end else begin
          r_d = r_q + RW'(1);
        end
      end
      S_DRAIN: begin
        if (d_last) begin
          d_d     = '0;
          state_d = S_IDLE;
        end else begin
          d_d = d_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stage 0 takes this cycle's issue; stage PL-1 lines up with the read data
    vld_d[0] = push_v;
    fst_d[0] = push_f;
    for (int i = 1; i < int'(PL); i++) begin
      vld_d[i] = vld_q[i-1];
      fst_d[i] = fst_q[i-1];
    end

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      c_d     = '0;
      p_d     = '0;
      r_d     = '0;
      d_d     = '0;
      vld_d   = '0;
      fst_d   = '0;
    end
  end

  // Memory control decode; idle values double as the chip-select gating
  always_comb begin
    KMEM_A1   = '0;
    KMEM_A2   = '0;
    WMEM_A1   = '0;
    WMEM_A2   = '0;
    KMEM_WEB1 = 1'b1;
    KMEM_OEB1 = 1'b1;
    KMEM_CSB1 = 1'b1;
    KMEM_WEB2 = 1'b1;
    KMEM_OEB2 = 1'b1;
    KMEM_CSB2 = 1'b1;
    WMEM_WEB1 = 1'b1;
    WMEM_OEB1 = 1'b1;
    WMEM_CSB1 = 1'b1;
    WMEM_WEB2 = 1'b1;
    WMEM_OEB2 = 1'b1;
    WMEM_CSB2 = 1'b1;
    done      = 1'b0;

    unique case (state_q)
      S_LEARN: begin
        KMEM_CSB1 = 1'b0;
        KMEM_WEB1 = 1'b0;
        KMEM_A1   = ADDR_W'(c_q);
        WMEM_CSB1 = 1'b0;
        WMEM_WEB1 = 1'b0;
        WMEM_CSB2 = 1'b0;
        WMEM_WEB2 = 1'b0;
        WMEM_A1   = ADDR_W'(c_q) << 1;
        WMEM_A2   = (ADDR_W'(c_q) << 1) + ADDR_W'(1);
        done      = c_last && !abort;
      end
      S_CLASSIFY: begin
        KMEM_CSB1 = 1'b0;
        KMEM_OEB1 = 1'b0;
        KMEM_CSB2 = 1'b0;
        KMEM_OEB2 = 1'b0;
        KMEM_A1   = ADDR_W'(p_q) << 1;
        KMEM_A2   = (ADDR_W'(p_q) << 1) + ADDR_W'(1);
        WMEM_CSB1 = 1'b0;
        WMEM_OEB1 = 1'b0;
        WMEM_A1   = (ADDR_W'(p_q) * ADDR_W'(CLASS_CYC)) + ADDR_W'(r_q);
      end
      S_DRAIN: begin
        done = d_last && !abort;
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign En       = vld_q[PL-1];
  assign En_first = fst_q[PL-1];

endmodule
